// File: rtl/contador_pkg.sv
// Shared types for the parametrised counter: mode encoding and run/done state.
package contador_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP,
      MODE_SAT,
      MODE_ONESHOT,
      MODE_RSVD
   } mode_e;

   typedef enum logic {
      ST_RUN,
      ST_DONE
   } state_e;

endpackage

// File: rtl/contador_next_calc.sv
// Next-count arithmetic: applies the step in a widened signed domain, then wraps or
// clips against [MIN_VAL, MAX_VAL] depending on mode.
module contador_next_calc
   import contador_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int MIN_VAL = 0,
   parameter int MAX_VAL = 2**WIDTH - 1,
   parameter int STEP_W  = 4
) (
   input  logic [WIDTH-1:0]  cont,
   input  logic              ud,
   input  logic [STEP_W-1:0] step,
   input  logic [1:0]        mode,
   output logic [WIDTH-1:0]  nxt_val,
   output logic              crossed,
   output logic              clipped
);

   localparam int EW = WIDTH + STEP_W + 1;
   localparam logic signed [EW-1:0] LO  = EW'(MIN_VAL);
   localparam logic signed [EW-1:0] HI  = EW'(MAX_VAL);
   localparam logic signed [EW-1:0] ONE = EW'(1);

   mode_e                m;
   logic signed [EW-1:0] ext_cont;
   logic signed [EW-1:0] ext_step;
   logic signed [EW-1:0] nxt;
   logic signed [EW-1:0] bound;
   logic                 past;
   logic                 reach;
   logic                 sat_mode;

   assign m = mode_e'(mode);

   always_comb begin
      ext_cont = $signed({{(EW-WIDTH){1'b0}}, cont});
      ext_step = $signed({{(EW-STEP_W){1'b0}}, step});
      nxt      = ud ? (ext_cont + ext_step) : (ext_cont - ext_step);
      bound    = ud ? HI : LO;
      past     = ud ? (nxt > HI) : (nxt < LO);
      reach    = ud ? (nxt >= HI) : (nxt <= LO);
      sat_mode = (m == MODE_SAT) || (m == MODE_ONESHOT);

      nxt_val  = WIDTH'(nxt);
      crossed  = 1'b0;
      clipped  = 1'b0;

      if (sat_mode) begin
         // tc only on the first arrival; sitting at the bound never re-fires it
         if (reach) begin
            nxt_val = WIDTH'(bound);
            crossed = (ext_cont != bound);
            clipped = past;
         end
      end else if (past) begin
         nxt_val = ud ? WIDTH'(LO + nxt - HI - ONE) : WIDTH'(HI - LO + nxt + ONE);
         crossed = 1'b1;
         clipped = 1'b1;
      end
   end

endmodule

// File: rtl/contador_param.sv
// Parametrised up/down counter with bounds, step, load, wrap/saturate/one-shot modes
// and terminal-count / sticky overflow status.
//
//   state   | meaning
//   ST_RUN  | counting allowed when en = 1
//   ST_DONE | one-shot reached its bound; en ignored until load or rst
module contador_param
   import contador_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int MIN_VAL = 0,
   parameter int MAX_VAL = 2**WIDTH - 1,
   parameter int STEP_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              ud,
   input  logic [STEP_W-1:0] step,
   input  logic [1:0]        mode,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              clr_ovf,
   output logic [WIDTH-1:0]  cont,
   output logic              at_max,
   output logic              at_min,
   output logic              tc,
   output logic              ovf,
   output logic              done
);

   localparam logic [WIDTH-1:0]        LO_W = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0]        HI_W = WIDTH'(MAX_VAL);
   localparam logic signed [WIDTH:0]   LO_S = (WIDTH+1)'(MIN_VAL);
   localparam logic signed [WIDTH:0]   HI_S = (WIDTH+1)'(MAX_VAL);

   state_e                 state;
   state_e                 state_nxt;
   logic [WIDTH-1:0]       cont_nxt;
   logic [WIDTH-1:0]       calc_val;
   logic [WIDTH-1:0]       load_clamped;
   logic signed [WIDTH:0]  lv;
   logic                   tc_nxt;
   logic                   ovf_nxt;
   logic                   crossed;
   logic                   clipped;
   logic                   count;
   logic                   term;

   contador_next_calc #(
      .WIDTH   (WIDTH),
      .MIN_VAL (MIN_VAL),
      .MAX_VAL (MAX_VAL),
      .STEP_W  (STEP_W)
   ) u_calc (
      .cont    (cont),
      .ud      (ud),
      .step    (step),
      .mode    (mode),
      .nxt_val (calc_val),
      .crossed (crossed),
      .clipped (clipped)
   );

   assign lv           = $signed({1'b0, load_val});
   assign load_clamped = (lv < LO_S) ? LO_W : ((lv > HI_S) ? HI_W : load_val);

   assign at_max = (cont == HI_W);
   assign at_min = (cont == LO_W);
   assign done   = (state == ST_DONE);

   always_comb begin
      count     = en && (state == ST_RUN);
      // a zero step is a no-op, so it must not finish a one-shot sitting on its bound
      term      = (mode_e'(mode) == MODE_ONESHOT) && (step != '0) &&
                  (calc_val == (ud ? HI_W : LO_W));
      state_nxt = state;
      cont_nxt  = cont;
      tc_nxt    = 1'b0;
      ovf_nxt   = clr_ovf ? 1'b0 : ovf;

      if (load) begin
         cont_nxt  = load_clamped;
         state_nxt = ST_RUN;
      end else if (count) begin
         cont_nxt = calc_val;
         tc_nxt   = crossed;
         if (clipped)
            ovf_nxt = 1'b1;
         if (term)
            state_nxt = ST_DONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RUN;
         cont  <= LO_W;
         tc    <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         cont  <= cont_nxt;
         tc    <= tc_nxt;
         ovf   <= ovf_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !load && count)
         assert (int'(step) <= MAX_VAL - MIN_VAL + 1);
   end

endmodule

// File: doc/contador_param.md
Name: contador_param

Overview:
- Parametrised successor of the 8-bit up/down counter.
- Adds a configurable width and bounds [MIN_VAL, MAX_VAL], count enable, programmable step and synchronous load.
- Three end-of-range modes: wrap, saturate and one-shot. Adds terminal-count and overflow status.
- Used as the general counter/timer primitive in the digital-systems project designs.

Parameters:
- WIDTH, 8, counter width in bits.
- MIN_VAL, 0, lower count bound, inclusive.
- MAX_VAL, 2**WIDTH-1, upper count bound, inclusive. Requires MIN_VAL < MAX_VAL < 2**WIDTH.
- STEP_W, 4, width of the step input.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  count enable.
- ud  in  1  direction: 1 = up, 0 = down.
- step  in  STEP_W  increment/decrement magnitude. 0 means no change.
- mode  in  2  mode select: 00 WRAP, 01 SAT, 10 ONESHOT, 11 treated as WRAP.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- clr_ovf  in  1  clears the sticky ovf flag.
- cont  out  WIDTH  registered count.
- at_max  out  1  combinational, cont == MAX_VAL.
- at_min  out  1  combinational, cont == MIN_VAL.
- tc  out  1  registered one-cycle pulse when a bound is crossed or reached.
- ovf  out  1  sticky flag, set when a step exceeds a bound.
- done  out  1  ONESHOT finished; counter is frozen.

Behaviour:
- Reset (rst = 1 at a clock edge):
  - cont = MIN_VAL; tc = 0; ovf = 0; done = 0; state = RUN.
- Priority per edge: rst > load > en. With en = 0 and no load, all registers hold, and tc returns to 0.
- Load:
  - cont = clamp(load_val, MIN_VAL, MAX_VAL).
  - State returns to RUN; done = 0; tc = 0.
  - Load is legal in any state and in any mode.
- Count arithmetic (en = 1, not loading, state RUN):
  - Compute nxt = cont ± step in WIDTH+STEP_W+1 bits. No truncation is allowed before the bound check.
  - Step is constrained to step ≤ MAX_VAL-MIN_VAL+1. Assert this in simulation.
- WRAP, up, nxt > MAX_VAL: cont = MIN_VAL + (nxt - MAX_VAL - 1); tc = 1; ovf set.
- WRAP, down, nxt < MIN_VAL: cont = MAX_VAL - (MIN_VAL - nxt - 1); tc = 1; ovf set.
- SAT, step would cross a bound: cont = that bound; tc = 1 only on the edge it first reaches the bound; ovf set only if the step was clipped.
  - Holding at the bound with further count requests: ovf stays set, no new tc.
- ONESHOT: same as SAT, plus when cont reaches the bound in the direction of counting, state goes to DONE and done = 1.
  - In DONE, en is ignored; only load or rst leaves it.
- In range: cont = nxt; tc = 0.
- Exact landing on a bound in WRAP gives tc = 0. tc marks wrap events only.
- ovf: set has priority over clr_ovf in the same cycle. Otherwise clr_ovf = 1 clears it.
- Latency: cont, tc, ovf and done update on the edge after the inputs are sampled. at_max/at_min follow cont combinationally.
- Mode change mid-count takes effect on the next enabled edge. No state reset.
- ud change takes effect immediately on the next enabled edge.
- FSM: RUN and DONE only. RUN→DONE on the ONESHOT terminal condition. DONE→RUN on load or rst.
- No $display in RTL. Debug prints belong in the testbench.

Decomposition:
- contador_pkg holds:
  - typedef enum logic[1:0] mode_e {MODE_WRAP, MODE_SAT, MODE_ONESHOT, MODE_RSVD}.
  - typedef enum logic {ST_RUN, ST_DONE} state_e.
- contador_next_calc: combinational sub-module taking cont, ud, step and mode. Returns next value, crossed flag and clipped flag.
- contador_param: owns the registers, FSM, load/priority logic and flags.

Test Plan:
- WIDTH=8, MIN=0, MAX=255, WRAP, ud=1, step=1, from 254, en for 3 cycles -> cont 255, 0, 1; tc pulses only on the 255→0 edge; ovf=1.
- MIN=10, MAX=20, WRAP, ud=0, step=3, load 11, then en -> cont 19 (11-3 wraps to 20-(10-8-1)=19); tc=1; ovf=1.
- MIN=10, MAX=20, SAT, ud=1, step=4, load 18, en for 3 cycles -> cont 20, 20, 20; tc once; ovf=1; clr_ovf together with another clipped step -> ovf stays 1; clr_ovf with en=0 -> ovf=0.
- ONESHOT, ud=1, step=1, load MAX-2, en held -> done rises when cont=MAX; further en leaves cont unchanged; load 5 -> done=0, counting resumes.
- load_val=250 with MIN=0, MAX=100 -> cont=100. Load together with en -> the load wins.
- Mid-count: rst=1 for one edge while en=1 and load=1 -> cont=MIN_VAL; tc=0; ovf=0; done=0. step=0 with en=1 -> cont unchanged.
